// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC, runs the instruction-memory req/ack handshake,
// and delivers {pc, inst} to decode through a one-entry skid buffer.
module pc_fetch_ctrl #(
   parameter int unsigned       DATA_SIZE = 32,
   parameter logic [DATA_SIZE-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [DATA_SIZE-1:0] NOP_INST = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 redirect_valid,
   input  logic [DATA_SIZE-1:0] redirect_target,
   input  logic                 stall,
   output logic                 im_req,
   output logic [DATA_SIZE-1:0] im_addr,
   input  logic                 im_ack,
   input  logic [DATA_SIZE-1:0] im_rdata,
   output logic                 if_valid,
   output logic [DATA_SIZE-1:0] if_pc,
   output logic [DATA_SIZE-1:0] if_inst
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]           state, state_n;
   logic [DATA_SIZE-1:0] pc, pc_n;
   logic [DATA_SIZE-1:0] tgt_q, tgt_n;
   logic                 skid_valid, skid_valid_n;
   logic [DATA_SIZE-1:0] skid_pc, skid_pc_n;
   logic [DATA_SIZE-1:0] skid_inst, skid_inst_n;
   logic                 if_valid_n;
   logic [DATA_SIZE-1:0] if_pc_n, if_inst_n;
   logic [DATA_SIZE-1:0] target_al;
   logic [DATA_SIZE-1:0] pc_inc;
   logic                 slot_free;

   assign target_al = redirect_target & ~DATA_SIZE'(3);
   assign pc_inc    = pc + DATA_SIZE'(4);
   assign slot_free = !if_valid || !stall;

   // In DROP the PC still holds the squashed address, so im_addr is always pc
   assign im_req  = (state == S_REQ) || (state == S_DROP);
   assign im_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         tgt_q      <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_inst  <= '0;
         if_valid   <= 1'b0;
         if_pc      <= '0;
         if_inst    <= NOP_INST;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         tgt_q      <= tgt_n;
         skid_valid <= skid_valid_n;
         skid_pc    <= skid_pc_n;
         skid_inst  <= skid_inst_n;
         if_valid   <= if_valid_n;
         if_pc      <= if_pc_n;
         if_inst    <= if_inst_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      tgt_n        = tgt_q;
      skid_valid_n = skid_valid;
      skid_pc_n    = skid_pc;
      skid_inst_n  = skid_inst;
      if_valid_n   = if_valid;
      if_pc_n      = if_pc;
      if_inst_n    = if_inst;

      if (redirect_valid) begin
         // Flush wins over stall
         if_valid_n   = 1'b0;
         if_inst_n    = NOP_INST;
         skid_valid_n = 1'b0;
         case (state)
            S_REQ: begin
               if (im_ack) begin
                  pc_n = target_al;
               end else begin
                  tgt_n   = target_al;
                  state_n = S_DROP;
               end
            end
            S_DROP: begin
               // Newest target wins; an ack this cycle completes the squashed request
               tgt_n = target_al;
               if (im_ack) begin
                  pc_n    = target_al;
                  state_n = S_REQ;
               end
            end
            default: begin
               pc_n    = target_al;
               state_n = S_REQ;
            end
         endcase
      end else begin
         case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
               if (im_ack) begin
                  pc_n = pc_inc;
                  if (slot_free) begin
                     if_valid_n = 1'b1;
                     if_pc_n    = pc;
                     if_inst_n  = im_rdata;
                  end else begin
                     skid_valid_n = 1'b1;
                     skid_pc_n    = pc;
                     skid_inst_n  = im_rdata;
                     state_n      = S_HOLD;
                  end
               end else if (slot_free) begin
                  if_valid_n = 1'b0;
                  if_inst_n  = NOP_INST;
               end
            end
            S_HOLD: begin
               if (slot_free) begin
                  if_valid_n   = skid_valid;
                  if_pc_n      = skid_pc;
                  if_inst_n    = skid_inst;
                  skid_valid_n = 1'b0;
                  state_n      = S_REQ;
               end
            end
            default: begin
               if (im_ack) begin
                  pc_n    = tgt_q;
                  state_n = S_REQ;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl: streaming, stall/skid, redirect/DROP,
// aligned redirect under stall, reset mid-DROP, and PC wrap.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        stall = 1'b0;
   logic        im_ack = 1'b0;
   logic [31:0] im_rdata = '0;
   logic        im_req;
   logic [31:0] im_addr;
   logic        if_valid;
   logic [31:0] if_pc, if_inst;

   logic        w_rst = 1'b1;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = '0;
   logic        w_im_req;
   logic [31:0] w_im_addr;
   logic        w_if_valid;
   logic [31:0] w_if_pc, w_if_inst;

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .stall(stall), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
   );

   pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst(w_rst), .redirect_valid(1'b0), .redirect_target(32'h0),
      .stall(1'b0), .im_req(w_im_req), .im_addr(w_im_addr), .im_ack(w_ack), .im_rdata(w_rdata),
      .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst)
   );

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] tgt;
      logic        stall;
      logic        ack;
      logic [31:0] rdata;
      logic        chk;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   localparam int unsigned NV = 23;
   vec_t vecs [NV];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] tgt,
                               input logic st, input logic ack, input logic [31:0] rd,
                               input logic chk, input logic req, input logic [31:0] addr,
                               input logic val, input logic [31:0] pc, input logic [31:0] inst);
      vec_t v;
      v.rst = r; v.rv = rv; v.tgt = tgt; v.stall = st; v.ack = ack; v.rdata = rd;
      v.chk = chk; v.e_req = req; v.e_addr = addr; v.e_val = val; v.e_pc = pc; v.e_inst = inst;
      return v;
   endfunction

   initial begin
      //             rst rv tgt           st ack rdata          chk req addr          val pc            inst
      vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        NOP);
      vecs[1]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        NOP);
      vecs[2]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        NOP);
      vecs[3]  = mk(0, 0, 32'h0,        0, 1, 32'hEEEE_EEEE, 1, 0, 32'h0,        0, 32'h0,        NOP);
      vecs[4]  = mk(0, 0, 32'h0,        0, 1, 32'h1000_0000, 1, 1, 32'h0,        0, 32'h0,        NOP);
      vecs[5]  = mk(0, 0, 32'h0,        0, 1, 32'h1000_0004, 1, 1, 32'h4,        1, 32'h0,        32'h1000_0000);
      vecs[6]  = mk(0, 0, 32'h0,        0, 1, 32'h1000_0008, 1, 1, 32'h8,        1, 32'h4,        32'h1000_0004);
      vecs[7]  = mk(0, 0, 32'h0,        1, 1, 32'h1000_000C, 1, 1, 32'hC,        1, 32'h8,        32'h1000_0008);
      vecs[8]  = mk(0, 0, 32'h0,        1, 0, 32'h0,         1, 0, 32'h10,       1, 32'h8,        32'h1000_0008);
      vecs[9]  = mk(0, 0, 32'h0,        1, 0, 32'h0,         1, 0, 32'h10,       1, 32'h8,        32'h1000_0008);
      vecs[10] = mk(0, 0, 32'h0,        1, 0, 32'h0,         1, 0, 32'h10,       1, 32'h8,        32'h1000_0008);
      vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 32'h10,       1, 32'h8,        32'h1000_0008);
      vecs[12] = mk(0, 1, 32'h200,      0, 0, 32'h0,         1, 1, 32'h10,       1, 32'hC,        32'h1000_000C);
      vecs[13] = mk(0, 1, 32'h300,      0, 0, 32'h0,         1, 1, 32'h10,       0, 32'hC,        NOP);
      vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h10,       0, 32'hC,        NOP);
      vecs[15] = mk(0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 1, 1, 32'h10,       0, 32'hC,        NOP);
      vecs[16] = mk(0, 0, 32'h0,        0, 1, 32'h1000_0300, 1, 1, 32'h300,      0, 32'hC,        NOP);
      vecs[17] = mk(0, 1, 32'h403,      1, 1, 32'hBAD0_0000, 1, 1, 32'h304,      1, 32'h300,      32'h1000_0300);
      vecs[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h400,      0, 32'h300,      NOP);
      vecs[19] = mk(0, 1, 32'h500,      0, 0, 32'h0,         1, 1, 32'h400,      0, 32'h300,      NOP);
      vecs[20] = mk(1, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h400,      0, 32'h300,      NOP);
      vecs[21] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 0, 32'h0,        0, 32'h0,        NOP);
      vecs[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h0,        0, 32'h0,        NOP);

      for (int i = 0; i < int'(NV); i++) begin
         @(negedge clk);
         rst             = vecs[i].rst;
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].tgt;
         stall           = vecs[i].stall;
         im_ack          = vecs[i].ack;
         im_rdata        = vecs[i].rdata;
         if (vecs[i].chk) begin
            check("im_req",   i, 32'(im_req),   32'(vecs[i].e_req));
            check("im_addr",  i, im_addr,       vecs[i].e_addr);
            check("if_valid", i, 32'(if_valid), 32'(vecs[i].e_val));
            check("if_pc",    i, if_pc,         vecs[i].e_pc);
            check("if_inst",  i, if_inst,       vecs[i].e_inst);
         end
      end

      // PC wrap from a high reset vector, ack tied high
      @(negedge clk);
      w_rst   = 1'b0;
      w_ack   = 1'b1;
      w_rdata = 32'hCAFE_0000;
      check("w_idle_req", 0, 32'(w_im_req), 32'd0);
      begin
         int k = 0;
         while (!w_im_req && k < 4) begin
            @(negedge clk);
            k++;
         end
      end
      check("w_req",  1, 32'(w_im_req), 32'd1);
      check("w_addr", 1, w_im_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      check("w_addr", 2, w_im_addr, 32'hFFFF_FFFC);
      check("w_pc",   2, w_if_pc,   32'hFFFF_FFF8);
      check("w_val",  2, 32'(w_if_valid), 32'd1);
      @(negedge clk);
      check("w_addr", 3, w_im_addr, 32'h0000_0000);
      check("w_pc",   3, w_if_pc,   32'hFFFF_FFFC);
      @(negedge clk);
      check("w_addr", 4, w_im_addr, 32'h0000_0004);
      check("w_pc",   4, w_if_pc,   32'h0000_0000);
      check("w_inst", 4, w_if_inst, 32'hCAFE_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
